sobel_edge_filter: RTL and testbench
====================================

Name: sobel_edge_filter

Overview:
Downstream consumer of the 3x3 pixel-window buffer. Takes the nine RGB444 window pixels plus the centre coordinate each readClk cycle and produces one processed RGB444 pixel for the VGA output path. Output modes are centre pass-through, grayscale, Sobel edge magnitude, or thresholded binary edge. The block is a fixed 4-stage pipeline. It also counts edge pixels per frame for debug LEDs and UART readout.

Parameters:
H_ACTIVE, 640, visible width; the last column is H_ACTIVE-1.
V_ACTIVE, 480, visible height; the last row is V_ACTIVE-1.
THRESH_RST, 8'h40, threshold value loaded at reset.

Ports:
readClk  in  1  pixel clock, shared with the window buffer.
reset  in  1  asynchronous, active-high reset.
inValid  in  1  the window and coordinates are valid this cycle.
inX  in  10  column of the centre pixel.
inY  in  9  row of the centre pixel.
pix_lu, pix_lm, pix_ld, pix_mu, pix_mm, pix_md, pix_ru, pix_rm, pix_rd  in  12 each  window pixels {R[11:8],G[7:4],B[3:0]}; l/m/r is column, u/m/d is row.
frameStart  in  1  one-cycle pulse at the first pixel of a frame.
modeIn  in  2  0 pass, 1 gray, 2 edge magnitude, 3 binary edge.
threshIn  in  8  binary edge threshold.
outValid  out  1  inValid delayed by 4 cycles.
outX  out  10  inX delayed by 4 cycles.
outY  out  9  inY delayed by 4 cycles.
outPixel  out  12  processed pixel.
edgeCount  out  19  binary-edge pixel count of the previous complete frame.

Behaviour:
- Clock and reset: one clock, readClk. reset is asynchronous and active-high. While reset is asserted, every pipeline register and output is 0, except: mode shadow = 0, threshold shadow = THRESH_RST.
- Shadow registers: modeIn and threshIn are captured only in a cycle where frameStart=1. They never change mid-frame.
  - If frameStart and inValid occur in the same cycle, the new values already apply to that pixel.
- Pipeline: no stall. Every stage register updates every cycle. Valid, X, Y and the centre pixel travel alongside the data. Latency is exactly 4 cycles.
- S1, gray conversion: g = R + 2G + B for each of the nine pixels, 6-bit unsigned, range 0..60.
- S2, Sobel: both results are 10-bit signed, range ±240.
  - Gx = (g_ru + 2g_rm + g_rd) - (g_lu + 2g_lm + g_ld)
  - Gy = (g_ld + 2g_md + g_rd) - (g_lu + 2g_mu + g_ru)
- S3, magnitude: mag = |Gx| + |Gy|, 9-bit, range 0..480. mag8 = 255 if mag > 255, else mag[7:0].
- S3, border forcing: if inX==0, inX==H_ACTIVE-1, inY==0 or inY==V_ACTIVE-1, force mag8 = 0.
- S4, output by mode:
  - mode 0: the centre pixel.
  - mode 1: {q,q,q} with q = g_mm >> 2.
  - mode 2: {m,m,m} with m = mag8[7:4].
  - mode 3: 12'hFFF if mag8 >= thresh, else 12'h000.
- Edge counter, running count:
  - Increments when the S4 pixel is valid AND mag8 >= thresh AND it is not a border pixel. This applies in every mode.
  - Saturates at 2^19-1.
- Edge counter, frame boundary: on frameStart, edgeCount <= running count and the running count is cleared.
  - If a counted pixel is in flight at frameStart, it goes to the new frame.
  - edgeCount holds its value between frameStart pulses.
- reset mid-frame: the pipeline flushes, outValid=0 the next cycle, and both counts return to 0.

Decomposition:
- Shared package (pixel_pkg): PIX_W=12, the channel slice constants, H_ACTIVE/V_ACTIVE, and the mode encodings MODE_PASS/GRAY/EDGE/BIN.
- Sub-module rgb444_to_gray (combinational, 12 in, 6 out): instanced nine times in S1, and reused in later display stages.

Test Plan:
1. reset high mid-stream → outValid=0, outPixel=0, edgeCount=0. Release reset, pulse frameStart with mode=0 → 4 cycles after inValid, outPixel=pix_mm.
2. Mode 1, uniform window of 12'h8C4 → g=36, outPixel=12'h999; outX/outY equal the inputs from 4 cycles earlier.
3. Mode 2, left column 12'h000 and middle/right columns 12'hFFF, inX=100 → Gx=240, Gy=0, mag8=240, outPixel=12'hFFF. Uniform window → 12'h000.
4. Mode 3, thresh=8'hF1, same edge window → 12'h000 (240<241). With thresh=8'hF0 → 12'hFFF.
5. Border: edge window at inX=0, then at inY=479 → outPixel=12'h000 in mode 3 and the pixels are not counted.
6. Counting: a frame with 1000 valid edge pixels, then frameStart → edgeCount=1000 the next cycle.
   - Change modeIn mid-frame → output mode unchanged until the next frameStart.
   - frameStart coinciding with a valid pixel → that pixel is processed in the new mode.

Source files
------------

// File: rtl/sobel_edge_filter_pkg.sv
// Pixel-format constants, display geometry and filter-mode encodings shared
// by the VGA post-processing blocks.
package pixel_pkg;

  localparam int PIX_W = 12;
  localparam int R_HI  = 11;
  localparam int R_LO  = 8;
  localparam int G_HI  = 7;
  localparam int G_LO  = 4;
  localparam int B_HI  = 3;
  localparam int B_LO  = 0;

  localparam int         H_ACTIVE   = 640;
  localparam int         V_ACTIVE   = 480;
  localparam logic [7:0] THRESH_RST = 8'h40;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_GRAY = 2'd1,
    MODE_EDGE = 2'd2,
    MODE_BIN  = 2'd3
  } mode_t;

  // Per-pixel side-band carried down the pipeline next to the arithmetic.
  typedef struct packed {
    logic             valid;
    logic [9:0]       x;
    logic [8:0]       y;
    logic [PIX_W-1:0] centre;
    mode_t            mode;
    logic [7:0]       thresh;
  } side_t;

endpackage

// File: rtl/sobel_edge_filter_if.sv
// Window-in / pixel-out bundle between the 3x3 window buffer, the Sobel
// filter and the VGA output path.
interface sobel_edge_filter_if;
  import pixel_pkg::*;

  logic             inValid;
  logic [9:0]       inX;
  logic [8:0]       inY;
  logic [PIX_W-1:0] pix_lu, pix_lm, pix_ld;
  logic [PIX_W-1:0] pix_mu, pix_mm, pix_md;
  logic [PIX_W-1:0] pix_ru, pix_rm, pix_rd;
  logic             frameStart;
  logic [1:0]       modeIn;
  logic [7:0]       threshIn;

  logic             outValid;
  logic [9:0]       outX;
  logic [8:0]       outY;
  logic [PIX_W-1:0] outPixel;
  logic [18:0]      edgeCount;

  modport master (
    output inValid, inX, inY, pix_lu, pix_lm, pix_ld, pix_mu, pix_mm, pix_md,
           pix_ru, pix_rm, pix_rd, frameStart, modeIn, threshIn,
    input  outValid, outX, outY, outPixel, edgeCount
  );

  modport slave (
    input  inValid, inX, inY, pix_lu, pix_lm, pix_ld, pix_mu, pix_mm, pix_md,
           pix_ru, pix_rm, pix_rd, frameStart, modeIn, threshIn,
    output outValid, outX, outY, outPixel, edgeCount
  );

endinterface

// File: rtl/sobel_edge_filter_gray.sv
// RGB444 to 6-bit luminance approximation g = R + 2G + B (0..60).
module rgb444_to_gray
  import pixel_pkg::*;
(
  input  logic [PIX_W-1:0] pix,
  output logic [5:0]       gray
);

  assign gray = {2'b00, pix[R_HI:R_LO]} + {1'b0, pix[G_HI:G_LO], 1'b0}
              + {2'b00, pix[B_HI:B_LO]};

endmodule

// File: rtl/sobel_edge_filter.sv
// Sobel edge / grayscale post-filter for the VGA path: fixed 4-stage pipeline
// with a per-frame edge-pixel counter for debug readout.
module sobel_edge_filter #(
  parameter int         H_ACTIVE   = pixel_pkg::H_ACTIVE,
  parameter int         V_ACTIVE   = pixel_pkg::V_ACTIVE,
  parameter logic [7:0] THRESH_RST = pixel_pkg::THRESH_RST
) (
  input logic                readClk,
  input logic                reset,
  sobel_edge_filter_if.slave bus
);
  import pixel_pkg::*;

  localparam logic [18:0] CNT_MAX = 19'h7FFFF;

  mode_t             modeShadow_r;
  logic [7:0]        threshShadow_r;
  side_t             sideIn_s, s1Side_r, s2Side_r, s3Side_r;
  logic [PIX_W-1:0]  winPix_s [9];
  logic [5:0]        gray_s [9];
  logic [5:0]        s1Gray_r [9];
  logic signed [9:0] gx_s, gy_s, s2Gx_r, s2Gy_r;
  logic [5:0]        s2GrayMm_r, s3GrayMm_r;
  logic [9:0]        absGx_s, absGy_s, magSum_s;
  logic [7:0]        mag8_s, s3Mag8_r;
  logic              border_s, s3Border_r, countHit_s;
  logic [PIX_W-1:0]  pixelOut_s, outPixel_r;
  logic              outValid_r;
  logic [9:0]        outX_r;
  logic [8:0]        outY_r;
  logic [18:0]       runCount_r, edgeCount_r;

  function automatic logic signed [9:0] sx(input logic [5:0] g);
    return $signed({4'b0000, g});
  endfunction

  // A frameStart pixel already uses the values arriving with it.
  always_comb begin
    sideIn_s        = '0;
    sideIn_s.valid  = bus.inValid;
    sideIn_s.x      = bus.inX;
    sideIn_s.y      = bus.inY;
    sideIn_s.centre = bus.pix_mm;
    if (bus.frameStart) begin
      sideIn_s.mode   = mode_t'(bus.modeIn);
      sideIn_s.thresh = bus.threshIn;
    end else begin
      sideIn_s.mode   = modeShadow_r;
      sideIn_s.thresh = threshShadow_r;
    end
  end

  // Mode/threshold shadows, frozen between frameStart pulses.
  always_ff @(posedge readClk or posedge reset) begin
    if (reset) begin
      modeShadow_r   <= MODE_PASS;
      threshShadow_r <= THRESH_RST;
    end else if (bus.frameStart) begin
      modeShadow_r   <= mode_t'(bus.modeIn);
      threshShadow_r <= bus.threshIn;
    end
  end

  assign winPix_s = '{bus.pix_lu, bus.pix_lm, bus.pix_ld, bus.pix_mu, bus.pix_mm,
                      bus.pix_md, bus.pix_ru, bus.pix_rm, bus.pix_rd};

  for (genvar i = 0; i < 9; i++) begin : g_gray
    rgb444_to_gray u_gray (.pix(winPix_s[i]), .gray(gray_s[i]));
  end

  // Index order: 0..2 left column (u,m,d), 3..5 middle, 6..8 right.
  assign gx_s = (sx(s1Gray_r[6]) + 10'sd2 * sx(s1Gray_r[7]) + sx(s1Gray_r[8]))
              - (sx(s1Gray_r[0]) + 10'sd2 * sx(s1Gray_r[1]) + sx(s1Gray_r[2]));
  assign gy_s = (sx(s1Gray_r[2]) + 10'sd2 * sx(s1Gray_r[5]) + sx(s1Gray_r[8]))
              - (sx(s1Gray_r[0]) + 10'sd2 * sx(s1Gray_r[3]) + sx(s1Gray_r[6]));

  // Magnitude, 8-bit clamp and border suppression.
  always_comb begin
    absGx_s  = s2Gx_r[9] ? $unsigned(-s2Gx_r) : $unsigned(s2Gx_r);
    absGy_s  = s2Gy_r[9] ? $unsigned(-s2Gy_r) : $unsigned(s2Gy_r);
    magSum_s = absGx_s + absGy_s;
    border_s = (s2Side_r.x == 10'd0) || (s2Side_r.x == 10'(H_ACTIVE - 1))
            || (s2Side_r.y == 9'd0)  || (s2Side_r.y == 9'(V_ACTIVE - 1));
    if (border_s) begin
      mag8_s = 8'd0;
    end else if (magSum_s > 10'd255) begin
      mag8_s = 8'd255;
    end else begin
      mag8_s = magSum_s[7:0];
    end
  end

  // Stage registers S1..S3; no stall, every stage loads every cycle.
  always_ff @(posedge readClk or posedge reset) begin
    if (reset) begin
      s1Side_r   <= '0;
      s1Gray_r   <= '{default: 6'd0};
      s2Side_r   <= '0;
      s2Gx_r     <= 10'sd0;
      s2Gy_r     <= 10'sd0;
      s2GrayMm_r <= 6'd0;
      s3Side_r   <= '0;
      s3Mag8_r   <= 8'd0;
      s3Border_r <= 1'b0;
      s3GrayMm_r <= 6'd0;
    end else begin
      s1Side_r   <= sideIn_s;
      s1Gray_r   <= gray_s;
      s2Side_r   <= s1Side_r;
      s2Gx_r     <= gx_s;
      s2Gy_r     <= gy_s;
      s2GrayMm_r <= s1Gray_r[4];
      s3Side_r   <= s2Side_r;
      s3Mag8_r   <= mag8_s;
      s3Border_r <= border_s;
      s3GrayMm_r <= s2GrayMm_r;
    end
  end

  // Output pixel selection by the mode that travelled with the pixel.
  always_comb begin
    pixelOut_s = 12'h000;
    case (s3Side_r.mode)
      MODE_PASS: pixelOut_s = s3Side_r.centre;
      MODE_GRAY: pixelOut_s = {3{s3GrayMm_r[5:2]}};
      MODE_EDGE: pixelOut_s = {3{s3Mag8_r[7:4]}};
      MODE_BIN: begin
        if (s3Mag8_r >= s3Side_r.thresh) pixelOut_s = 12'hFFF;
        else pixelOut_s = 12'h000;
      end
      default:   pixelOut_s = 12'h000;
    endcase
  end

  // Border is excluded explicitly: with thresh 0 the forced mag8 would still pass.
  assign countHit_s = s3Side_r.valid && !s3Border_r && (s3Mag8_r >= s3Side_r.thresh);

  // S4 output registers.
  always_ff @(posedge readClk or posedge reset) begin
    if (reset) begin
      outValid_r <= 1'b0;
      outX_r     <= 10'd0;
      outY_r     <= 9'd0;
      outPixel_r <= 12'h000;
    end else begin
      outValid_r <= s3Side_r.valid;
      outX_r     <= s3Side_r.x;
      outY_r     <= s3Side_r.y;
      outPixel_r <= pixelOut_s;
    end
  end

  // Saturating edge counter; a hit coinciding with frameStart opens the new frame.
  always_ff @(posedge readClk or posedge reset) begin
    if (reset) begin
      runCount_r  <= 19'd0;
      edgeCount_r <= 19'd0;
    end else if (bus.frameStart) begin
      edgeCount_r <= runCount_r;
      runCount_r  <= countHit_s ? 19'd1 : 19'd0;
    end else if (countHit_s && (runCount_r != CNT_MAX)) begin
      runCount_r <= runCount_r + 19'd1;
    end
  end

  assign bus.outValid  = outValid_r;
  assign bus.outX      = outX_r;
  assign bus.outY      = outY_r;
  assign bus.outPixel  = outPixel_r;
  assign bus.edgeCount = edgeCount_r;

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Self-checking bench for sobel_edge_filter: directed scenarios plus random
// windows against a frame-level arithmetic reference model.
module tb_sobel_edge_filter;

  typedef struct packed {
    logic        v;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [11:0] pix;
    logic        hit;
    logic        hasWant;
    logic [11:0] want;
  } exp_t;

  logic readClk = 1'b0;
  logic reset   = 1'b1;
  int   checks  = 0;
  int   failures = 0;

  sobel_edge_filter_if bus();
  sobel_edge_filter dut (.readClk(readClk), .reset(reset), .bus(bus));

  always #5 readClk = ~readClk;

  logic [11:0] win [9];
  exp_t        pipeQ [$];
  logic [1:0]  mShadow;
  logic [7:0]  tShadow;
  int          runCnt, edgeCnt;

  function automatic int grayOf(input logic [11:0] p);
    return int'(p[11:8]) + 2 * int'(p[7:4]) + int'(p[3:0]);
  endfunction

  function automatic exp_t model(input logic [11:0] w [9], input logic v, input logic [9:0] x,
                                 input logic [8:0] y, input logic [1:0] m, input logic [7:0] t);
    int g [9];
    int gx, gy, mag;
    logic [7:0] m8;
    logic [3:0] n;
    logic border;
    exp_t e;
    for (int i = 0; i < 9; i++) g[i] = grayOf(w[i]);
    gx = (g[6] + 2 * g[7] + g[8]) - (g[0] + 2 * g[1] + g[2]);
    gy = (g[2] + 2 * g[5] + g[8]) - (g[0] + 2 * g[3] + g[6]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    border = (x == 10'd0) || (x == 10'd639) || (y == 9'd0) || (y == 9'd479);
    m8 = border ? 8'd0 : (mag > 255 ? 8'd255 : 8'(mag));
    e = '0;
    e.v = v; e.x = x; e.y = y;
    e.hit = v && !border && (m8 >= t);
    case (m)
      2'd0: e.pix = w[4];
      2'd1: begin n = 4'(g[4] / 4); e.pix = {n, n, n}; end
      2'd2: begin n = m8[7:4]; e.pix = {n, n, n}; end
      default: e.pix = (m8 >= t) ? 12'hFFF : 12'h000;
    endcase
    return e;
  endfunction

  task automatic randWin();
    for (int i = 0; i < 9; i++) win[i] = 12'($urandom);
  endtask

  task automatic uniWin(input logic [11:0] c);
    for (int i = 0; i < 9; i++) win[i] = c;
  endtask

  task automatic edgeWin();
    for (int i = 0; i < 9; i++) win[i] = (i < 3) ? 12'h000 : 12'hFFF;
  endtask

  task automatic modelReset();
    pipeQ.delete();
    repeat (3) pipeQ.push_back(exp_t'(0));
    mShadow = 2'd0; tShadow = 8'h40; runCnt = 0; edgeCnt = 0;
  endtask

  task automatic assertReset();
    @(negedge readClk);
    reset = 1'b1; bus.inValid = 1'b0; bus.frameStart = 1'b0;
    modelReset();
  endtask

  task automatic releaseReset();
    @(negedge readClk);
    reset = 1'b0;
  endtask

  // One clock: drive a window, advance the model, return the entry now at the output.
  task automatic step(input logic v, input logic [9:0] x, input logic [8:0] y, input logic fs,
                      input logic [1:0] m, input logic [7:0] t, input logic hw,
                      input logic [11:0] want, output exp_t e);
    logic [1:0] em;
    logic [7:0] et;
    exp_t n;
    @(negedge readClk);
    bus.inValid = v; bus.inX = x; bus.inY = y; bus.frameStart = fs;
    bus.modeIn = m; bus.threshIn = t;
    bus.pix_lu = win[0]; bus.pix_lm = win[1]; bus.pix_ld = win[2];
    bus.pix_mu = win[3]; bus.pix_mm = win[4]; bus.pix_md = win[5];
    bus.pix_ru = win[6]; bus.pix_rm = win[7]; bus.pix_rd = win[8];
    em = fs ? m : mShadow;
    et = fs ? t : tShadow;
    if (fs) begin mShadow = m; tShadow = t; end
    n = model(win, v, x, y, em, et);
    n.hasWant = hw; n.want = want;
    pipeQ.push_back(n);
    @(posedge readClk); #1;
    e = pipeQ.pop_front();
    if (fs) begin
      edgeCnt = runCnt;
      runCnt = e.hit ? 1 : 0;
    end else if (e.hit && runCnt < 524287) begin
      runCnt++;
    end
  endtask

  task automatic flush(input string tag, input int n);
    exp_t e;
    uniWin(12'h000);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 10'd0, 9'd0, 1'b0, 2'd0, 8'd0, 1'b0, 12'h000, e);
      checks++;
      if (bus.outValid !== e.v) begin failures++; $display("FAIL %s_flush_valid: got %0b want %0b", tag, bus.outValid, e.v); end
      if (e.v) begin
        checks++;
        if ({bus.outX, bus.outY, bus.outPixel} !== {e.x, e.y, e.pix}) begin
          failures++; $display("FAIL %s_flush_pix: got x=%0d y=%0d pix=%h want x=%0d y=%0d pix=%h", tag, bus.outX, bus.outY, bus.outPixel, e.x, e.y, e.pix);
        end
        if (e.hasWant) begin
          checks++;
          if (bus.outPixel !== e.want) begin failures++; $display("FAIL %s_flush_const: got %h want %h", tag, bus.outPixel, e.want); end
        end
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      randWin();
      step(1'b1, 10'd200, 9'd200, 1'b0, 2'd0, 8'd0, 1'b1, win[4], e);
    end
    assertReset(); #1;
    checks++; if (bus.outValid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", bus.outValid); end
    checks++; if (bus.outPixel !== 12'h000) begin failures++; $display("FAIL reset_pixel: got %h want 000", bus.outPixel); end
    checks++; if (bus.edgeCount !== 19'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", bus.edgeCount); end
    releaseReset();
    for (int i = 0; i < 12; i++) begin
      randWin();
      step(1'b1, 10'(100 + i), 9'd50, (i == 8), 2'd0, 8'h10, 1'b1, win[4], e);
      checks++;
      if (bus.outValid !== e.v) begin failures++; $display("FAIL reset_pass_valid: got %0b want %0b", bus.outValid, e.v); end
      if (e.v) begin
        checks++;
        if ({bus.outX, bus.outY, bus.outPixel} !== {e.x, e.y, e.want}) begin
          failures++; $display("FAIL reset_pass: got x=%0d y=%0d pix=%h want x=%0d y=%0d pix=%h", bus.outX, bus.outY, bus.outPixel, e.x, e.y, e.want);
        end
      end
      if (i == 8) begin
        checks++;
        if (bus.edgeCount !== 19'(edgeCnt)) begin failures++; $display("FAIL reset_frame_count: got %0d want %0d", bus.edgeCount, edgeCnt); end
      end
    end
    flush("reset", 3);
  endtask

  task automatic test_gray();
    exp_t e;
    uniWin(12'h8C4);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 10'($urandom_range(638, 1)), 9'($urandom_range(478, 1)), (i == 0), 2'd1, 8'h00, 1'b1, 12'h999, e);
      checks++;
      if (bus.outValid !== e.v) begin failures++; $display("FAIL gray_valid: got %0b want %0b", bus.outValid, e.v); end
      if (e.v) begin
        checks++;
        if ({bus.outX, bus.outY, bus.outPixel} !== {e.x, e.y, e.pix}) begin
          failures++; $display("FAIL gray_model: got x=%0d y=%0d pix=%h want x=%0d y=%0d pix=%h", bus.outX, bus.outY, bus.outPixel, e.x, e.y, e.pix);
        end
      end
    end
    flush("gray", 3);
  endtask

  task automatic test_edge();
    exp_t e;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin
        edgeWin();
        step(1'b1, 10'd100, 9'd100, 1'b1, 2'd2, 8'h00, 1'b1, 12'hFFF, e);
      end else if (i == 1) begin
        uniWin(12'($urandom));
        step(1'b1, 10'd101, 9'd100, 1'b0, 2'd2, 8'h00, 1'b1, 12'h000, e);
      end else begin
        randWin();
        if (i % 3 == 0) win[4] = win[0];
        step(1'b1, 10'($urandom_range(638, 1)), 9'($urandom_range(478, 1)), 1'b0, 2'd2, 8'h00, 1'b0, 12'h000, e);
      end
      checks++;
      if (bus.outValid !== e.v) begin failures++; $display("FAIL edge_valid: got %0b want %0b", bus.outValid, e.v); end
      if (e.v) begin
        checks++;
        if ({bus.outX, bus.outY, bus.outPixel} !== {e.x, e.y, e.pix}) begin
          failures++; $display("FAIL edge_model: got x=%0d y=%0d pix=%h want x=%0d y=%0d pix=%h", bus.outX, bus.outY, bus.outPixel, e.x, e.y, e.pix);
        end
        if (e.hasWant) begin
          checks++;
          if (bus.outPixel !== e.want) begin failures++; $display("FAIL edge_const: got %h want %h", bus.outPixel, e.want); end
        end
      end
    end
    flush("edge", 3);
  endtask

  task automatic test_binary();
    exp_t e;
    logic [7:0] t;
    for (int f = 0; f < 6; f++) begin
      t = (f == 0) ? 8'hF1 : (f == 1) ? 8'hF0 : 8'($urandom_range(255, 0));
      for (int i = 0; i < 6; i++) begin
        if (i == 0 && f < 2) edgeWin(); else randWin();
        step(1'b1, 10'($urandom_range(638, 1)), 9'($urandom_range(478, 1)), (i == 0), 2'd3, t,
             (i == 0 && f < 2), (f == 0) ? 12'h000 : 12'hFFF, e);
        checks++;
        if (bus.outValid !== e.v) begin failures++; $display("FAIL bin_valid: got %0b want %0b", bus.outValid, e.v); end
        if (e.v) begin
          checks++;
          if ({bus.outX, bus.outY, bus.outPixel} !== {e.x, e.y, e.pix}) begin
            failures++; $display("FAIL bin_model: got x=%0d y=%0d pix=%h want x=%0d y=%0d pix=%h", bus.outX, bus.outY, bus.outPixel, e.x, e.y, e.pix);
          end
          if (e.hasWant) begin
            checks++;
            if (bus.outPixel !== e.want) begin failures++; $display("FAIL bin_thresh: got %h want %h", bus.outPixel, e.want); end
          end
        end
      end
    end
    flush("bin", 3);
  endtask

  task automatic test_border();
    exp_t e;
    logic [9:0] xs [5];
    logic [8:0] ys [5];
    xs = '{10'd0, 10'd100, 10'd639, 10'd300, 10'd100};
    ys = '{9'd100, 9'd479, 9'd200, 9'd0, 9'd100};
    edgeWin();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, xs[i], ys[i], (i == 0), 2'd3, 8'hF0, 1'b1, (i == 4) ? 12'hFFF : 12'h000, e);
      checks++;
      if (bus.outValid !== e.v) begin failures++; $display("FAIL border_valid: got %0b want %0b", bus.outValid, e.v); end
      if (e.v && e.hasWant) begin
        checks++;
        if (bus.outPixel !== e.want) begin failures++; $display("FAIL border_pix: got %h want %h", bus.outPixel, e.want); end
      end
    end
    flush("border", 4);
    step(1'b0, 10'd0, 9'd0, 1'b1, 2'd3, 8'hF0, 1'b0, 12'h000, e);
    checks++;
    if (bus.edgeCount !== 19'd1) begin failures++; $display("FAIL border_count: got %0d want 1", bus.edgeCount); end
  endtask

  task automatic test_count();
    exp_t e;
    edgeWin();
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 10'(1 + (i % 600)), 9'(1 + (i / 600)), (i == 0), (i < 500) ? 2'd2 : 2'd1, 8'hF0, 1'b1, 12'hFFF, e);
      if (e.v && e.hasWant) begin
        checks++;
        if (bus.outPixel !== e.want) begin failures++; $display("FAIL count_mode_hold: got %h want %h at pixel %0d", bus.outPixel, e.want, i); end
      end
    end
    flush("count", 4);
    uniWin(12'h8C4);
    step(1'b1, 10'd320, 9'd240, 1'b1, 2'd1, 8'hF0, 1'b1, 12'h999, e);
    checks++;
    if (bus.edgeCount !== 19'd1000) begin failures++; $display("FAIL count_frame: got %0d want 1000", bus.edgeCount); end
    flush("count_newmode", 3);
  endtask

  task automatic test_random();
    exp_t e;
    logic [9:0] x;
    logic [8:0] y;
    for (int i = 0; i < 800; i++) begin
      x = 10'($urandom_range(638, 1));
      y = 9'($urandom_range(478, 1));
      case ($urandom_range(9, 0))
        0: x = 10'd0;
        1: x = 10'd639;
        2: y = 9'd0;
        3: y = 9'd479;
        default: ;
      endcase
      if ($urandom_range(3, 0) == 0) uniWin(12'($urandom)); else randWin();
      step(($urandom_range(9, 0) != 0), x, y, ($urandom_range(39, 0) == 0), 2'($urandom),
           8'($urandom_range(255, 0)), 1'b0, 12'h000, e);
      checks++;
      if (bus.outValid !== e.v) begin failures++; $display("FAIL rand_valid: got %0b want %0b", bus.outValid, e.v); end
      if (e.v) begin
        checks++;
        if ({bus.outX, bus.outY, bus.outPixel} !== {e.x, e.y, e.pix}) begin
          failures++; $display("FAIL rand_model: got x=%0d y=%0d pix=%h want x=%0d y=%0d pix=%h", bus.outX, bus.outY, bus.outPixel, e.x, e.y, e.pix);
        end
      end
      checks++;
      if (bus.edgeCount !== 19'(edgeCnt)) begin failures++; $display("FAIL rand_count: got %0d want %0d", bus.edgeCount, edgeCnt); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.inValid = 1'b0; bus.inX = 10'd0; bus.inY = 9'd0; bus.frameStart = 1'b0;
    bus.modeIn = 2'd0; bus.threshIn = 8'd0;
    uniWin(12'h000);
    bus.pix_lu = 12'h000; bus.pix_lm = 12'h000; bus.pix_ld = 12'h000;
    bus.pix_mu = 12'h000; bus.pix_mm = 12'h000; bus.pix_md = 12'h000;
    bus.pix_ru = 12'h000; bus.pix_rm = 12'h000; bus.pix_rd = 12'h000;
    modelReset();
    repeat (3) @(posedge readClk);
    releaseReset();
    test_reset();
    test_gray();
    test_edge();
    test_binary();
    test_border();
    test_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
